// File: rtl/add_pkg.sv
// add_pkg: shared widths and FSM encoding for the bit-serial adder
package add_pkg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic r,
    output logic co
);
    // sum and carry of one bit position
    always_comb begin
        r  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
    end
endmodule

// File: rtl/add_8bit_serial.sv
// add_8bit_serial: signed 8-bit adder using one full-adder cell over 8 clocks
module add_8bit_serial
    import add_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ci,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             of
);
    state_t             state;
    logic [WIDTH-1:0]   x_sr;
    logic [WIDTH-1:0]   y_sr;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               c6;
    logic               fa_s;
    logic               fa_co;

    full_adder u_fa (
        .x  (x_sr[0]),
        .y  (y_sr[0]),
        .ci (carry),
        .r  (fa_s),
        .co (fa_co)
    );

    // control FSM plus shift datapath; results are published only when entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_sr  <= '0;
            y_sr  <= '0;
            r_sr  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            c6    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            co    <= 1'b0;
            of    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_sr  <= x;
                        y_sr  <= y;
                        carry <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x_sr  <= x_sr >> 1;
                    y_sr  <= y_sr >> 1;
                    r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 2))
                        c6 <= fa_co;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        r     <= {fa_s, r_sr[WIDTH-1:1]};
                        co    <= fa_co;
                        of    <= fa_co ^ c6;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_8bit_serial.sv
// tb_add_8bit_serial: directed self-checking bench for the bit-serial adder
module tb_add_8bit_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ci = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       busy;
    logic       done;
    logic [7:0] r;
    logic       co;
    logic       of;

    int n_cmp = 0;
    int n_bad = 0;

    add_8bit_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ci    (ci),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .co    (co),
        .of    (of)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] er, input logic eco, input logic eof);
        logic [7:0] prev;
        prev  = r;
        start = 1'b1;
        x = a;
        y = b;
        ci = c;
        tick();
        start = 1'b0;
        x = 8'hA5;
        y = 8'h5A;
        ci = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("busy_c%0d", i), {7'd0, busy}, 8'd1);
            chk($sformatf("nodone_c%0d", i), {7'd0, done}, 8'd0);
            chk($sformatf("rhold_c%0d", i), r, prev);
            tick();
        end
        chk("done_c9", {7'd0, done}, 8'd1);
        chk("busy_c9", {7'd0, busy}, 8'd0);
        chk($sformatf("r_%h_%h_%0d", a, b, c), r, er);
        chk($sformatf("co_%h_%h_%0d", a, b, c), {7'd0, co}, {7'd0, eco});
        chk($sformatf("of_%h_%h_%0d", a, b, c), {7'd0, of}, {7'd0, eof});
        tick();
        chk("done_c10", {7'd0, done}, 8'd0);
        chk("busy_c10", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_r", r, 8'h00);
        chk("rst_flags", {6'd0, co, of}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {7'd0, busy}, 8'd0);

        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op(8'h10, 8'h0F, 1'b1, 8'h20, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        start = 1'b1; x = 8'h11; y = 8'h22; ci = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin
                start = 1'b1; x = 8'h55; y = 8'h55; ci = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("ign_busy_c%0d", i), {7'd0, busy}, 8'd1);
            chk($sformatf("ign_nodone_c%0d", i), {7'd0, done}, 8'd0);
            tick();
        end
        chk("ign_done_c9", {7'd0, done}, 8'd1);
        chk("ign_r_c9", r, 8'h33);
        chk("ign_flags_c9", {6'd0, co, of}, 8'd0);
        for (int i = 10; i <= 13; i++) begin
            tick();
            chk($sformatf("ign_rhold_c%0d", i), r, 8'h33);
            chk($sformatf("ign_idle_c%0d", i), {6'd0, busy, done}, 8'd0);
        end

        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        start = 1'b1; x = 8'h40; y = 8'h40; ci = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        chk("arst_r", r, 8'h00);
        chk("arst_flags", {6'd0, co, of}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("arst_nodone_%0d", i), {6'd0, busy, done}, 8'd0);
            tick();
        end
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        start = 1'b1; x = 8'h05; y = 8'h03; ci = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("b2b_busy_c%0d", i), {7'd0, busy}, 8'd1);
            tick();
        end
        chk("b2b_done_c9", {7'd0, done}, 8'd1);
        chk("b2b_r_c9", r, 8'h08);
        x = 8'h20; y = 8'h22;
        tick();
        for (int i = 10; i <= 17; i++) begin
            if (i == 11) start = 1'b0;
            chk($sformatf("b2b_busy_c%0d", i), {7'd0, busy}, 8'd1);
            chk($sformatf("b2b_nodone_c%0d", i), {7'd0, done}, 8'd0);
            chk($sformatf("b2b_rhold_c%0d", i), r, 8'h08);
            tick();
        end
        chk("b2b_done_c18", {7'd0, done}, 8'd1);
        chk("b2b_r_c18", r, 8'h42);
        chk("b2b_flags_c18", {6'd0, co, of}, 8'd0);
        tick();
        chk("b2b_done_c19", {7'd0, done}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
